// File: rtl/hcsr04_medidor.sv
// hcsr04_medidor: HC-SR04 ultrasonic front end for the digital tape measure.
//
// A start request (medir) makes the block fire a trigger pulse to the sensor.
// It then times the echo pulse and converts the echo width into a distance in
// centimetres. The distance is presented as three BCD digits on medida, and
// pronto pulses for one cycle when medida is updated.
//
// The BCD count is rounded half up and saturates at 999.
//
// Optional feature, enabled by defining HCSR04_MEDIDOR_TIMEOUT_EN:
//   A watchdog aborts a measurement when the echo never rises, or when the
//   echo stays high too long. An aborted measurement reports erro for one
//   cycle and sets medida to 999.
// When the macro is undefined:
//   erro is tied low.
//   The block waits indefinitely for the echo.

module hcsr04_medidor #(
    parameter int TRIGGER_CYCLES = 500,
    parameter int CICLOS_POR_CM  = 2941,
    parameter int TIMEOUT_CYCLES = 1_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARACAO    = 4'd1,
        ENVIA_TRIGGER = 4'd2,
        ESPERA_ECHO   = 4'd3,
        MEDINDO       = 4'd4,
        ARMAZENA      = 4'd5,
        FINAL_MEDIDA  = 4'd6,
        TIMEOUT       = 4'd7
    } estado_t;

    // Counters only ever hold 0 .. N-1, so clog2(N) bits are enough.
    localparam int TW = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES) : 1;
    localparam int DW = (CICLOS_POR_CM > 1) ? $clog2(CICLOS_POR_CM) : 1;

    localparam logic [TW-1:0] TRIG_ULTIMO = TW'(TRIGGER_CYCLES - 1);
    localparam logic [DW-1:0] DIV_ULTIMO  = DW'(CICLOS_POR_CM - 1);
    localparam logic [DW-1:0] DIV_METADE  = DW'(CICLOS_POR_CM / 2);

`ifdef HCSR04_MEDIDOR_TIMEOUT_EN
    localparam int OW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [OW-1:0] TO_ULTIMO = OW'(TIMEOUT_CYCLES - 1);
    logic [OW-1:0] cnt_timeout;
`endif

    estado_t       estado;
    logic [TW-1:0] cnt_trigger;
    logic [DW-1:0] divisor;
    logic [11:0]   bcd;

    logic echo_s1;
    logic echo_s2;
    logic echo_ant;
    logic echo_sobe;
    logic echo_desce;

    // Adds one to a three-digit BCD value, carrying between digits.
    // The value sticks at 999 instead of wrapping around.
    function automatic logic [11:0] bcd_mais_um(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Two-flop synchronizer for the asynchronous echo, plus one delayed copy
    // that is used for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_s1  <= 1'b0;
            echo_s2  <= 1'b0;
            echo_ant <= 1'b0;
        end else begin
            echo_s1  <= echo;
            echo_s2  <= echo_s1;
            echo_ant <= echo_s2;
        end
    end

    assign echo_sobe  = echo_s2 & ~echo_ant;
    assign echo_desce = ~echo_s2 & echo_ant;
    assign db_estado  = estado;

`ifndef HCSR04_MEDIDOR_TIMEOUT_EN
    assign erro = 1'b0;
`endif

    // Measurement sequencer.
    // Every output is registered: pronto and erro are high only during the
    // single cycle spent in final_medida and timeout, respectively.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= INICIAL;
            trigger     <= 1'b0;
            pronto      <= 1'b0;
            medida      <= 12'h000;
            cnt_trigger <= '0;
            divisor     <= '0;
            bcd         <= 12'h000;
`ifdef HCSR04_MEDIDOR_TIMEOUT_EN
            erro        <= 1'b0;
            cnt_timeout <= '0;
`endif
        end else begin
            pronto <= 1'b0;
`ifdef HCSR04_MEDIDOR_TIMEOUT_EN
            erro   <= 1'b0;
`endif
            case (estado)
                INICIAL: begin
                    if (medir) begin
                        estado <= PREPARACAO;
                    end
                end

                PREPARACAO: begin
                    cnt_trigger <= '0;
                    divisor     <= '0;
                    bcd         <= 12'h000;
                    trigger     <= 1'b1;
                    estado      <= ENVIA_TRIGGER;
                end

                ENVIA_TRIGGER: begin
                    if (cnt_trigger == TRIG_ULTIMO) begin
                        trigger <= 1'b0;
                        estado  <= ESPERA_ECHO;
`ifdef HCSR04_MEDIDOR_TIMEOUT_EN
                        cnt_timeout <= '0;
`endif
                    end else begin
                        cnt_trigger <= cnt_trigger + 1'b1;
                    end
                end

                ESPERA_ECHO: begin
                    if (echo_sobe) begin
                        divisor <= '0;
                        bcd     <= 12'h000;
                        estado  <= MEDINDO;
`ifdef HCSR04_MEDIDOR_TIMEOUT_EN
                        cnt_timeout <= '0;
                    end else if (cnt_timeout == TO_ULTIMO) begin
                        erro   <= 1'b1;
                        medida <= 12'h999;
                        estado <= TIMEOUT;
                    end else begin
                        cnt_timeout <= cnt_timeout + 1'b1;
`endif
                    end
                end

                MEDINDO: begin
                    // The cycle in which the fall is seen still counts.
                    // This makes the count equal the echo width in clock cycles.
                    if (divisor == DIV_ULTIMO) begin
                        divisor <= '0;
                        bcd     <= bcd_mais_um(bcd);
                    end else begin
                        divisor <= divisor + 1'b1;
                    end
                    if (echo_desce) begin
                        estado <= ARMAZENA;
`ifdef HCSR04_MEDIDOR_TIMEOUT_EN
                    end else if (cnt_timeout == TO_ULTIMO) begin
                        erro   <= 1'b1;
                        medida <= 12'h999;
                        estado <= TIMEOUT;
                    end else begin
                        cnt_timeout <= cnt_timeout + 1'b1;
`endif
                    end
                end

                ARMAZENA: begin
                    medida <= (divisor >= DIV_METADE) ? bcd_mais_um(bcd) : bcd;
                    pronto <= 1'b1;
                    estado <= FINAL_MEDIDA;
                end

                FINAL_MEDIDA: begin
                    estado <= INICIAL;
                end

                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

endmodule
